// File: rtl/arbitro_somador_pkg.sv
// Shared definitions for arbitro_somador: datapath width, FSM states and
// the round-robin winner rule.
package arbitro_somador_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Winner index among the valid requesters; with both valid, the requester
  // that was not granted last wins. Returns 0 when neither is valid.
  function automatic logic rr_winner(input logic v0, input logic v1,
                                     input logic last_grant);
    if (v0 && v1) return ~last_grant;
    else if (v1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/somador4bits.sv
// Plain 4-bit adder, result wraps modulo 16 (carry discarded).
module somador4bits
  import arbitro_somador_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] saida
);

  assign saida = a + b;

endmodule

// File: rtl/arbitro_somador.sv
// arbitro_somador: two requesters share one 4-bit adder through a
// round-robin arbiter. One operation in flight: IDLE -> CALC -> RESP.
// Optional feature: define ARBITRO_SOMADOR_OVF_EN to add the rsp_ovf
// output (carry out of the 4-bit sum).
module arbitro_somador
  import arbitro_somador_pkg::*;
#(
  parameter bit START_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              r1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
`ifdef ARBITRO_SOMADOR_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic [DATA_W-1:0] rsp_sum
);

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_id;
  logic [DATA_W-1:0]   r_sum;
  logic                r_last_grant;
  logic [DATA_W-1:0]   w_sum;
  logic                w_winner;
  logic                w_grant_en;
  logic                w_accept;

  // Arbitration is only offered in IDLE and never while reset is asserted,
  // since the async reset holds the state register at IDLE.
  assign w_winner   = rr_winner(r0_valid, r1_valid, r_last_grant);
  assign w_grant_en = (r_state == IDLE) && rst_n;
  assign r0_ready   = w_grant_en && r0_valid && !w_winner;
  assign r1_ready   = w_grant_en && r1_valid &&  w_winner;
  assign w_accept   = (r0_valid && r0_ready) || (r1_valid && r1_ready);

  // The single shared adder, fed only from the registered operands.
  somador4bits u_somador (
    .a     (r_a),
    .b     (r_b),
    .saida (w_sum)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_next_state = CALC;
      CALC:                   w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // Operand capture on accept, sum capture in CALC, grant history on
  // response handshake.
  // NOTE: every datapath register is reset so a killed operation leaves
  // no stale result visible after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_sum        <= '0;
      r_last_grant <= ~START_PRIO;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_a  <= w_winner ? r1_a : r0_a;
        r_b  <= w_winner ? r1_b : r0_b;
        r_id <= w_winner;
      end
      if (r_state == CALC) begin
        r_sum <= w_sum;
      end
      if (r_state == RESP && rsp_ready) begin
        r_last_grant <= r_id;
      end
    end
  end

`ifdef ARBITRO_SOMADOR_OVF_EN
  logic r_ovf;
  logic w_carry;

  // Carry out of the MSB recovered from the operand and sum MSBs: when the
  // operand MSBs differ, the sum MSB is the inverse of the incoming carry.
  assign w_carry = (r_a[DATA_W-1] & r_b[DATA_W-1]) |
                   ((r_a[DATA_W-1] ^ r_b[DATA_W-1]) & ~w_sum[DATA_W-1]);

  // Overflow flag registered alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (r_state == CALC)  r_ovf <= w_carry;
  end

  assign rsp_ovf = r_ovf;
`endif

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;

endmodule
